// File: rtl/ps_mem_responder_if.sv
// Processor memory, run-control and host load/dump signals of ps_mem_responder.
// slave = responder view, master = processor/host view.
interface ps_mem_responder_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] im_addr;
  logic                  im_rd;
  logic [DATA_WIDTH-1:0] im_r_data;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic                  dm_rd;
  logic                  dm_wr;
  logic [DATA_WIDTH-1:0] dm_w_data;
  logic [DATA_WIDTH-1:0] dm_r_data;
  logic                  start;
  logic                  stop;
  logic                  go;
  logic                  ld_valid;
  logic                  ld_sel;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_ready;
  logic                  dump_valid;
  logic [ADDR_WIDTH-1:0] dump_addr;
  logic [DATA_WIDTH-1:0] dump_data;
  logic                  dump_ready;
  logic                  done;

  modport slave (
    input  im_addr, im_rd, dm_addr, dm_rd, dm_wr, dm_w_data, stop, go,
           ld_valid, ld_sel, ld_addr, ld_data, dump_ready,
    output im_r_data, dm_r_data, start, ld_ready, dump_valid, dump_addr,
           dump_data, done
  );

  modport master (
    output im_addr, im_rd, dm_addr, dm_rd, dm_wr, dm_w_data, stop, go,
           ld_valid, ld_sel, ld_addr, ld_data, dump_ready,
    input  im_r_data, dm_r_data, start, ld_ready, dump_valid, dump_addr,
           dump_data, done
  );
endinterface

// File: rtl/ps_mem_responder.sv
// IM/DM owner and test-host sequencer (preload, start, run, dump, done) for the 16-bit processor.
// Define PS_MEM_DUMP_EN to build the post-run DM dump stream; without it stop goes straight to DONE.
module ps_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  ps_mem_responder_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_RUN      = 3'd2,
    S_DUMP_RD  = 3'd3,
    S_DUMP_OUT = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_im [DEPTH];
  logic [DATA_WIDTH-1:0] r_dm [DEPTH];
  logic [DATA_WIDTH-1:0] r_im_r_data;
  logic [DATA_WIDTH-1:0] r_dm_r_data;
  logic                  r_start;
  logic                  r_ld_ready;
  logic                  r_done;
  logic                  w_im_we;
  logic                  w_dm_we;
  logic                  w_im_rd;
  logic                  w_dm_rd;
  logic [ADDR_WIDTH-1:0] w_dm_waddr;
  logic [DATA_WIDTH-1:0] w_dm_wdata;
`ifdef PS_MEM_DUMP_EN
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_dump_data;
  logic                  r_dump_valid;
  logic                  w_cnt_clr;
  logic                  w_cnt_inc;
  logic                  w_dump_load;
`endif

  // Next state plus memory-port steering: loads only in IDLE, processor accesses only in RUN
  always_comb begin
    w_state_nxt = r_state;
    w_im_we     = 1'b0;
    w_dm_we     = 1'b0;
    w_im_rd     = 1'b0;
    w_dm_rd     = 1'b0;
    w_dm_waddr  = bus.ld_addr;
    w_dm_wdata  = bus.ld_data;
`ifdef PS_MEM_DUMP_EN
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_dump_load = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.ld_valid) begin
          w_im_we = ~bus.ld_sel;
          w_dm_we = bus.ld_sel;
        end else begin
          w_im_we = 1'b0;
          w_dm_we = 1'b0;
        end
        if (bus.go) begin
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_im_rd    = bus.im_rd;
        w_dm_rd    = bus.dm_rd;
        w_dm_we    = bus.dm_wr;
        w_dm_waddr = bus.dm_addr;
        w_dm_wdata = bus.dm_w_data;
        if (bus.stop) begin
`ifdef PS_MEM_DUMP_EN
          w_state_nxt = S_DUMP_RD;
          w_cnt_clr   = 1'b1;
`else
          w_state_nxt = S_DONE;
`endif
        end else begin
          w_state_nxt = S_RUN;
        end
      end
`ifdef PS_MEM_DUMP_EN
      S_DUMP_RD: begin
        w_dump_load = 1'b1;
        w_state_nxt = S_DUMP_OUT;
      end
      S_DUMP_OUT: begin
        if (bus.dump_ready) begin
          if (r_cnt == LAST_ADDR) begin
            w_state_nxt = S_DONE;
          end else begin
            w_cnt_inc   = 1'b1;
            w_state_nxt = S_DUMP_RD;
          end
        end else begin
          w_state_nxt = S_DUMP_OUT;
        end
      end
`endif
      S_DONE: begin
        if (bus.go) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register with control outputs registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_start    <= 1'b0;
      r_ld_ready <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_start    <= (w_state_nxt == S_START);
      r_ld_ready <= (w_state_nxt == S_IDLE);
      r_done     <= (w_state_nxt == S_DONE);
    end
  end

  // Array writes carry no reset so contents survive rst
  always_ff @(posedge clk) begin
    if (w_im_we) r_im[bus.ld_addr] <= bus.ld_data;
    if (w_dm_we) r_dm[w_dm_waddr] <= w_dm_wdata;
  end

  // Processor read data; same-edge DM write lands after this read (read-before-write)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_im_r_data <= {DATA_WIDTH{1'b0}};
      r_dm_r_data <= {DATA_WIDTH{1'b0}};
    end else begin
      if (w_im_rd) r_im_r_data <= r_im[bus.im_addr];
      if (w_dm_rd) r_dm_r_data <= r_dm[bus.dm_addr];
    end
  end

`ifdef PS_MEM_DUMP_EN
  // Dump counter and word register; cnt doubles as the dump address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= {ADDR_WIDTH{1'b0}};
      r_dump_data  <= {DATA_WIDTH{1'b0}};
      r_dump_valid <= 1'b0;
    end else begin
      r_dump_valid <= (w_state_nxt == S_DUMP_OUT);
      if (w_cnt_clr) begin
        r_cnt <= {ADDR_WIDTH{1'b0}};
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end
      if (w_dump_load) r_dump_data <= r_dm[r_cnt];
    end
  end

  assign bus.dump_valid = r_dump_valid;
  assign bus.dump_addr  = r_cnt;
  assign bus.dump_data  = r_dump_data;
`else
  assign bus.dump_valid = 1'b0;
  assign bus.dump_addr  = {ADDR_WIDTH{1'b0}};
  assign bus.dump_data  = {DATA_WIDTH{1'b0}};
`endif

  assign bus.im_r_data = r_im_r_data;
  assign bus.dm_r_data = r_dm_r_data;
  assign bus.start     = r_start;
  assign bus.ld_ready  = r_ld_ready;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_ps_mem_responder.sv
// Randomized self-checking bench for ps_mem_responder against a sequence-level reference model.
`timescale 1ns/1ps
module tb_ps_mem_responder;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int DEPTH = 256;
`ifdef PS_MEM_DUMP_EN
  localparam bit DUMP_EN = 1'b1;
`else
  localparam bit DUMP_EN = 1'b0;
`endif
  localparam int P_IDLE = 0, P_START = 1, P_RUN = 2, P_DRD = 3, P_DOUT = 4, P_DONE = 5;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   start_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ps_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  ps_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Reference model: sequence phase, memory images and the values the outputs must show
  int          m_phase;
  logic [7:0]  m_cnt;
  logic [15:0] m_im [DEPTH];
  logic [15:0] m_dm [DEPTH];
  logic [15:0] m_im_r, m_dm_r, m_dump;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= P_IDLE; m_cnt <= 8'h00; m_im_r <= 16'h0000; m_dm_r <= 16'h0000; m_dump <= 16'h0000;
    end else begin
      case (m_phase)
        P_IDLE: begin
          if (bus.ld_valid && bus.ld_sel) m_dm[bus.ld_addr] <= bus.ld_data;
          if (bus.ld_valid && !bus.ld_sel) m_im[bus.ld_addr] <= bus.ld_data;
          if (bus.go) m_phase <= P_START;
        end
        P_START: m_phase <= P_RUN;
        P_RUN: begin
          if (bus.im_rd) m_im_r <= m_im[bus.im_addr];
          if (bus.dm_rd) m_dm_r <= m_dm[bus.dm_addr];
          if (bus.dm_wr) m_dm[bus.dm_addr] <= bus.dm_w_data;
          if (bus.stop) begin
            m_phase <= DUMP_EN ? P_DRD : P_DONE;
            m_cnt   <= 8'h00;
          end
        end
        P_DRD: begin
          m_dump  <= m_dm[m_cnt];
          m_phase <= P_DOUT;
        end
        P_DOUT: begin
          if (bus.dump_ready && m_cnt == 8'hFF) m_phase <= P_DONE;
          else if (bus.dump_ready) begin
            m_cnt   <= m_cnt + 8'd1;
            m_phase <= P_DRD;
          end
        end
        P_DONE: if (bus.go) m_phase <= P_IDLE;
        default: m_phase <= P_IDLE;
      endcase
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model
  always @(posedge clk) begin
    #1;
    if (bus.start === 1'b1) start_cnt++;
    cmp("start",      32'(bus.start),      32'(m_phase == P_START));
    cmp("ld_ready",   32'(bus.ld_ready),   32'(m_phase == P_IDLE));
    cmp("done",       32'(bus.done),       32'(m_phase == P_DONE));
    cmp("dump_valid", 32'(bus.dump_valid), 32'(DUMP_EN && m_phase == P_DOUT));
    cmp("dump_addr",  32'(bus.dump_addr),  32'(DUMP_EN ? m_cnt : 8'h00));
    cmp("dump_data",  32'(bus.dump_data),  32'(DUMP_EN ? m_dump : 16'h0000));
    cmp("im_r_data",  32'(bus.im_r_data),  32'(m_im_r));
    cmp("dm_r_data",  32'(bus.dm_r_data),  32'(m_dm_r));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.im_addr = 8'h00; bus.im_rd = 1'b0; bus.dm_addr = 8'h00; bus.dm_rd = 1'b0;
    bus.dm_wr = 1'b0; bus.dm_w_data = 16'h0000; bus.stop = 1'b0; bus.go = 1'b0;
    bus.ld_valid = 1'b0; bus.ld_sel = 1'b0; bus.ld_addr = 8'h00; bus.ld_data = 16'h0000;
    bus.dump_ready = 1'b0;
  endtask

  // From IDLE: go, check the single start cycle, land in RUN
  task automatic go_run();
    bus.go = 1'b1; tick(); bus.go = 1'b0;
    cmp("start_after_go", 32'(bus.start), 32'h1);
    tick();
    cmp("start_one_cycle", 32'(bus.start), 32'h0);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      bus.dump_ready = 1'b1; tick(); n++;
    end
    cmp("done_reached", 32'(bus.done), 32'h1);
    bus.dump_ready = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    cmp({tag, "_ld_ready"},   32'(bus.ld_ready),   32'h1);
    cmp({tag, "_start"},      32'(bus.start),      32'h0);
    cmp({tag, "_done"},       32'(bus.done),       32'h0);
    cmp({tag, "_dump_valid"}, 32'(bus.dump_valid), 32'h0);
    cmp({tag, "_dump_addr"},  32'(bus.dump_addr),  32'h0);
    cmp({tag, "_dump_data"},  32'(bus.dump_data),  32'h0);
    cmp({tag, "_im_r_data"},  32'(bus.im_r_data),  32'h0);
    cmp({tag, "_dm_r_data"},  32'(bus.dm_r_data),  32'h0);
  endtask

  initial begin
    int hold, n;
    bit seen6, checked6, saw_beef;
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    check_reset_values("rst");
    rst = 1'b0;
    tick();

    // Preload IM/DM with stray processor writes in IDLE; go arrives with the last DM word
    for (int i = 0; i < 2 * DEPTH; i++) begin
      bus.ld_valid  = 1'b1;
      bus.ld_sel    = (i >= DEPTH);
      bus.ld_addr   = 8'(i);
      bus.ld_data   = (i < DEPTH) ? (16'h1000 + 16'(i)) : ((i == DEPTH + 5) ? 16'hBEEF : 16'h0000);
      bus.go        = (i == 2 * DEPTH - 1);
      bus.dm_wr     = 1'($urandom_range(0, 1));
      bus.dm_addr   = 8'($urandom);
      bus.dm_w_data = 16'hDEAD;
      tick();
    end
    idle_inputs();
    cmp("first_start", 32'(bus.start), 32'h1);
    bus.stop = 1'b1;
    tick();
    tick();

`ifdef PS_MEM_DUMP_EN
    hold = 0; n = 0; seen6 = 1'b0; checked6 = 1'b0;
    while (bus.done !== 1'b1 && n < 4000) begin
      if (seen6 && !checked6) begin
        cmp("bp_next_addr", 32'(bus.dump_addr), 32'h06);
        checked6 = 1'b1;
      end
      if (bus.dump_valid && bus.dump_addr == 8'h05 && !seen6) begin
        cmp("bp_valid", 32'(bus.dump_valid), 32'h1);
        cmp("bp_data",  32'(bus.dump_data),  32'hBEEF);
        if (hold < 5) begin bus.dump_ready = 1'b0; hold++; end
        else begin bus.dump_ready = 1'b1; seen6 = 1'b1; end
      end else begin
        bus.dump_ready = ($urandom_range(0, 3) != 0);
      end
      tick(); n++;
    end
    cmp("bp_hold_cycles", 32'(hold), 32'd5);
    cmp("dump_last_addr", 32'(bus.dump_addr), 32'hFF);
`endif
    wait_done(20);
    cmp("start_pulse_count", 32'(start_cnt), 32'd1);
    bus.stop = 1'b0;

    // DONE -> IDLE -> START -> RUN; directed processor accesses
    bus.go = 1'b1; tick(); bus.go = 1'b0;
    go_run();
    bus.dm_wr = 1'b1; bus.dm_addr = 8'h10; bus.dm_w_data = 16'h1234; tick();
    bus.dm_wr = 1'b0; bus.dm_rd = 1'b1; tick();
    cmp("dm_rd_after_wr", 32'(bus.dm_r_data), 32'h1234);
    bus.dm_rd = 1'b0; bus.im_rd = 1'b1; bus.im_addr = 8'h02; tick();
    bus.im_rd = 1'b0;
    cmp("im_rd_02", 32'(bus.im_r_data), 32'h1002);
    cmp("dm_rd_holds", 32'(bus.dm_r_data), 32'h1234);
    bus.dm_wr = 1'b1; bus.dm_addr = 8'h20; bus.dm_w_data = 16'h0001; tick();
    bus.dm_rd = 1'b1; bus.dm_w_data = 16'h00FF; tick();
    cmp("collide_old", 32'(bus.dm_r_data), 32'h0001);
    bus.dm_wr = 1'b0; tick();
    cmp("collide_reread", 32'(bus.dm_r_data), 32'h00FF);
    bus.dm_addr = 8'h05; tick();
    bus.dm_rd = 1'b0;
    cmp("dm_rd_beef", 32'(bus.dm_r_data), 32'hBEEF);

    // Random processor traffic with stray loads and go in RUN
    for (int i = 0; i < 300; i++) begin
      bus.im_rd     = 1'($urandom_range(0, 1));
      bus.im_addr   = 8'($urandom);
      bus.dm_rd     = 1'($urandom_range(0, 1));
      bus.dm_wr     = 1'($urandom_range(0, 1));
      bus.dm_addr   = 8'($urandom_range(6, 255));
      bus.dm_w_data = 16'($urandom);
      bus.ld_valid  = 1'($urandom_range(0, 1));
      bus.ld_sel    = 1'($urandom_range(0, 1));
      bus.ld_addr   = 8'($urandom);
      bus.ld_data   = 16'hBAD0;
      bus.go        = 1'($urandom_range(0, 1));
      tick();
    end
    bus.go = 1'b0; bus.ld_valid = 1'b0;

`ifdef PS_MEM_DUMP_EN
    bus.stop = 1'b1; tick();
    idle_inputs();
    n = 0;
    while (!(bus.dump_valid && bus.dump_addr == 8'h40) && n < 1000) begin
      bus.dump_ready = ($urandom_range(0, 1) != 0); tick(); n++;
    end
    cmp("reached_dump_40", 32'(bus.dump_addr), 32'h40);
`endif
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    idle_inputs();
    tick();
    rst = 1'b0;
    tick();
    check_reset_values("postrst");

    // Rerun with no preload: sweep both arrays through the processor ports
    go_run();
    for (int i = 0; i < DEPTH; i++) begin
      bus.im_rd = 1'b1; bus.im_addr = 8'(i); bus.dm_rd = 1'b1; bus.dm_addr = 8'(i);
      tick();
      if (i == 5) cmp("sweep_dm5", 32'(bus.dm_r_data), 32'hBEEF);
      if (i == 3) cmp("sweep_im3", 32'(bus.im_r_data), 32'h1003);
    end
    idle_inputs();
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
`ifdef PS_MEM_DUMP_EN
    n = 0; saw_beef = 1'b0;
    while (bus.done !== 1'b1 && n < 2000) begin
      if (bus.dump_valid && bus.dump_addr == 8'h05 && !saw_beef) begin
        cmp("rerun_dump_beef", 32'(bus.dump_data), 32'hBEEF);
        saw_beef = 1'b1;
      end
      bus.dump_ready = 1'b1; tick(); n++;
    end
    cmp("rerun_saw_addr5", 32'(saw_beef), 32'h1);
`endif
    wait_done(20);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
